// File: rtl/fetch_sequencer.sv
// Program-counter sequencer (IDLE/RUN/WAIT/DONE) with load stall insertion.
// Optional watchdog enabled by defining FETCH_SEQ_WATCHDOG_EN (adds WDOG_LIMIT and Timeout).
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int LOAD_STALL = 1,
  parameter int OFF_W      = 6
`ifdef FETCH_SEQ_WATCHDOG_EN
  ,
  parameter int WDOG_LIMIT = 4096
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Ack,
  input  logic            GotoEn,
  input  logic            Jump2En,
  input  logic            BranchEn,
  input  logic            LoadInst,
  input  logic            Zero,
  input  logic [PC_W-1:0] TargetAddr,
  input  logic [OFF_W-1:0] BranchOff,
  output logic [PC_W-1:0] ProgCtr,
  output logic            WrSuppress,
  output logic            Busy,
  output logic            Done
`ifdef FETCH_SEQ_WATCHDOG_EN
  ,
  output logic            Timeout
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  localparam logic [PC_W-1:0] START_PC   = PC_W'(START_ADDR);
  localparam logic [1:0]      STALL_INIT = 2'(LOAD_STALL - 1);
  localparam bit              STALL_EN   = (LOAD_STALL > 0);

  state_t          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [1:0]      r_stall, w_stall_next;
  logic            r_busy, r_done;
  logic            w_wr_suppress;
  logic [PC_W-1:0] w_off_ext;

  assign w_off_ext = PC_W'($signed(BranchOff));

`ifdef FETCH_SEQ_WATCHDOG_EN
  logic [15:0] r_wdog, w_wdog_next;
  logic        r_timeout, w_timeout_next;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_stall_next  = r_stall;
    w_wr_suppress = 1'b1;
`ifdef FETCH_SEQ_WATCHDOG_EN
    w_wdog_next    = r_wdog;
    w_timeout_next = r_timeout;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_state_next = S_RUN;
          w_pc_next    = START_PC;
`ifdef FETCH_SEQ_WATCHDOG_EN
          w_wdog_next    = '0;
          w_timeout_next = 1'b0;
`endif
        end
      end
      S_RUN: begin
        w_wr_suppress = 1'b0;
        if (Ack) begin
          w_state_next = S_DONE;
        end else if (STALL_EN && LoadInst) begin
          // Block the load's register write until the data has arrived.
          w_wr_suppress = 1'b1;
          w_state_next  = S_WAIT;
          w_stall_next  = STALL_INIT;
        end else if (GotoEn || (Jump2En && Zero)) begin
          w_pc_next = TargetAddr;
        end else if (BranchEn && Zero) begin
          w_pc_next = r_pc + w_off_ext;
        end else begin
          w_pc_next = r_pc + 1'b1;
        end
      end
      S_WAIT: begin
        if (r_stall != 2'd0) begin
          w_stall_next = r_stall - 2'd1;
        end else begin
          w_wr_suppress = 1'b0;
          w_pc_next     = r_pc + 1'b1;
          w_state_next  = S_RUN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
`ifdef FETCH_SEQ_WATCHDOG_EN
    if ((r_state == S_RUN) || (r_state == S_WAIT)) begin
      w_wdog_next = r_wdog + 16'd1;
      if (w_wdog_next == 16'(WDOG_LIMIT)) begin
        w_state_next   = S_DONE;
        w_pc_next      = r_pc;
        w_timeout_next = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
      r_stall <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_stall <= w_stall_next;
      r_busy  <= (w_state_next == S_RUN) || (w_state_next == S_WAIT);
      r_done  <= (w_state_next == S_DONE);
    end
  end

`ifdef FETCH_SEQ_WATCHDOG_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wdog    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog    <= w_wdog_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign Timeout = r_timeout;
`endif

  assign ProgCtr    = r_pc;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign WrSuppress = w_wr_suppress;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed literal checks plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_fetch_sequencer;
  localparam int PC_W  = 10;
  localparam int START = 0;
  localparam int LS    = 2;
  localparam int OFF_W = 6;
  localparam int MASK  = (1 << PC_W) - 1;
`ifdef FETCH_SEQ_WATCHDOG_EN
  localparam int WDOG  = 4096;
`endif

  logic             Clk = 1'b0;
  logic             Reset, Start, Ack, GotoEn, Jump2En, BranchEn, LoadInst, Zero;
  logic [PC_W-1:0]  TargetAddr;
  logic [OFF_W-1:0] BranchOff;
  logic [PC_W-1:0]  ProgCtr;
  logic             WrSuppress, Busy, Done;
`ifdef FETCH_SEQ_WATCHDOG_EN
  logic             Timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  fetch_sequencer #(
    .PC_W(PC_W), .START_ADDR(START), .LOAD_STALL(LS), .OFF_W(OFF_W)
`ifdef FETCH_SEQ_WATCHDOG_EN
    , .WDOG_LIMIT(WDOG)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .GotoEn(GotoEn),
    .Jump2En(Jump2En), .BranchEn(BranchEn), .LoadInst(LoadInst), .Zero(Zero),
    .TargetAddr(TargetAddr), .BranchOff(BranchOff), .ProgCtr(ProgCtr),
    .WrSuppress(WrSuppress), .Busy(Busy), .Done(Done)
`ifdef FETCH_SEQ_WATCHDOG_EN
    , .Timeout(Timeout)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Literal checks in the directed section also log one line each.
  task automatic lchk(input string name, input int act, input int exp);
    chk(name, act, exp);
    $display("[TB] %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_strobes();
    Start = 0; Ack = 0; GotoEn = 0; Jump2En = 0; BranchEn = 0;
    LoadInst = 0; Zero = 0; TargetAddr = '0; BranchOff = '0;
  endtask

  task automatic goto_pc(input int addr);
    GotoEn = 1; TargetAddr = PC_W'(addr);
    tick();
    clear_strobes();
  endtask

  // Behavioural model: phase 0 idle, 1 executing, 2 waiting on a load, 3 finished.
  int m_phase = 0, m_pc = START, m_left = 0;
  bit m_valid = 0;
`ifdef FETCH_SEQ_WATCHDOG_EN
  int m_cnt = 0;
  bit m_to = 0;
`endif

  always @(negedge Clk) begin
    int e_wrs, off, old_pc;
    bit was_busy;
    if (m_valid) begin
      chk("pc", int'(ProgCtr), m_pc);
      chk("busy", int'(Busy), int'(m_phase == 1 || m_phase == 2));
      chk("done", int'(Done), int'(m_phase == 3));
      if (m_phase == 1)      e_wrs = Ack ? 0 : ((LoadInst && LS > 0) ? 1 : 0);
      else if (m_phase == 2) e_wrs = (m_left > 0) ? 1 : 0;
      else                   e_wrs = 1;
      chk("wrsup", int'(WrSuppress), e_wrs);
`ifdef FETCH_SEQ_WATCHDOG_EN
      chk("timeout", int'(Timeout), int'(m_to));
`endif
    end
    off = int'(BranchOff);
    if (off >= (1 << (OFF_W - 1))) off = off - (1 << OFF_W);
    if (Reset) begin
      m_phase = 0; m_pc = START; m_left = 0; m_valid = 1;
`ifdef FETCH_SEQ_WATCHDOG_EN
      m_cnt = 0; m_to = 0;
`endif
    end else if (m_valid) begin
      was_busy = (m_phase == 1 || m_phase == 2);
      old_pc   = m_pc;
      case (m_phase)
        0, 3: if (Start) begin
          m_phase = 1; m_pc = START;
`ifdef FETCH_SEQ_WATCHDOG_EN
          m_cnt = 0; m_to = 0;
`endif
        end
        1: begin
          if (Ack) m_phase = 3;
          else if (LoadInst && LS > 0) begin m_phase = 2; m_left = LS - 1; end
          else if (GotoEn || (Jump2En && Zero)) m_pc = int'(TargetAddr);
          else if (BranchEn && Zero) m_pc = (m_pc + off) & MASK;
          else m_pc = (m_pc + 1) & MASK;
        end
        default: begin
          if (m_left > 0) m_left--;
          else begin m_pc = (m_pc + 1) & MASK; m_phase = 1; end
        end
      endcase
`ifdef FETCH_SEQ_WATCHDOG_EN
      if (was_busy) begin
        m_cnt++;
        if (m_cnt == WDOG) begin m_phase = 3; m_pc = old_pc; m_to = 1; end
      end
`else
      if (was_busy && old_pc < 0) m_pc = old_pc;
`endif
    end
  end

  initial begin
    Reset = 1;
    clear_strobes();
    repeat (2) tick();
    lchk("reset_pc", int'(ProgCtr), 0);
    lchk("reset_busy", int'(Busy), 0);
    lchk("reset_done", int'(Done), 0);
    lchk("reset_wrsup", int'(WrSuppress), 1);
    Reset = 0;
    tick();
    lchk("idle_pc", int'(ProgCtr), 0);
    Start = 1; tick(); Start = 0;
    lchk("start_pc_c2", int'(ProgCtr), 0);
    lchk("start_busy_c2", int'(Busy), 1);
    tick(); lchk("start_pc_c3", int'(ProgCtr), 1);
    tick(); lchk("start_pc_c4", int'(ProgCtr), 2);
    tick(); lchk("start_pc_c5", int'(ProgCtr), 3);
    Reset = 1; tick(); Reset = 0;
    lchk("midrun_reset_pc", int'(ProgCtr), 0);
    lchk("midrun_reset_busy", int'(Busy), 0);

    Start = 1; tick(); Start = 0;
    goto_pc(5);
    lchk("goto_pc5", int'(ProgCtr), 5);
    GotoEn = 1; Jump2En = 1; Zero = 1; TargetAddr = 10'd40;
    tick(); clear_strobes();
    lchk("goto_jump_pc40", int'(ProgCtr), 40);
    goto_pc(5);
    Jump2En = 1; Zero = 0; TargetAddr = 10'd40;
    tick(); clear_strobes();
    lchk("jump_notaken_pc6", int'(ProgCtr), 6);
    goto_pc(20);
    BranchEn = 1; Zero = 1; BranchOff = 6'b111100;
    tick(); clear_strobes();
    lchk("branch_back_pc16", int'(ProgCtr), 16);
    goto_pc(1023);
    lchk("pc_max", int'(ProgCtr), 1023);
    tick();
    lchk("pc_wrap", int'(ProgCtr), 0);

    goto_pc(8);
    LoadInst = 1; #1;
    lchk("load_wrsup_1", int'(WrSuppress), 1);
    tick();
    LoadInst = 0; GotoEn = 1; TargetAddr = 10'd99;
    lchk("load_hold_pc_2", int'(ProgCtr), 8); #1;
    lchk("load_wrsup_2", int'(WrSuppress), 1);
    tick();
    lchk("load_hold_pc_3", int'(ProgCtr), 8); #1;
    lchk("load_wrsup_3", int'(WrSuppress), 0);
    tick(); clear_strobes();
    lchk("load_pc_next", int'(ProgCtr), 9);

    goto_pc(12);
    Ack = 1; #1;
    lchk("ack_wrsup", int'(WrSuppress), 0);
    tick(); Ack = 0;
    lchk("ack_done", int'(Done), 1);
    lchk("ack_busy", int'(Busy), 0);
    lchk("ack_pc", int'(ProgCtr), 12);
    tick();
    lchk("done_hold_pc", int'(ProgCtr), 12);
    lchk("done_wrsup", int'(WrSuppress), 1);
    Start = 1; tick(); Start = 0;
    lchk("restart_pc", int'(ProgCtr), 0);
    lchk("restart_done", int'(Done), 0);
    tick();
    Start = 1; tick(); Start = 0;
    lchk("start_in_run_pc", int'(ProgCtr), 2);
    lchk("start_in_run_done", int'(Done), 0);

    for (int i = 0; i < 4000; i++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      Start      = ($urandom_range(0, 2) == 0);
      Ack        = ($urandom_range(0, 29) == 0);
      GotoEn     = ($urandom_range(0, 5) == 0);
      Jump2En    = ($urandom_range(0, 3) == 0);
      BranchEn   = ($urandom_range(0, 3) == 0);
      LoadInst   = ($urandom_range(0, 5) == 0);
      Zero       = $urandom_range(0, 1) == 1;
      TargetAddr = PC_W'($urandom);
      BranchOff  = OFF_W'($urandom);
      tick();
    end
    clear_strobes();
    Reset = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-state program-counter sequencer for the 9-bit-instruction core; sits between the instruction ROM and the control decoder.
- Owns ProgCtr and the run/halt state, and resolves next-PC from the decoder's GotoEn / Jump2En / BranchEn / Ack strobes plus the ALU Zero flag.
- Inserts programmable stall cycles for loads so data-memory read latency is hidden from the single-cycle datapath.

Parameters:
- PC_W, 10, program counter width in bits; instruction ROM depth is 2^PC_W.
- START_ADDR, 0, PC value loaded on reset and on every Start.
- LOAD_STALL, 1, extra cycles a load holds the PC (0..3).
- OFF_W, 6, width of the signed relative branch offset.

Ports:
- Clk  in  1  clock, all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin program; sampled in IDLE and DONE only.
- Ack  in  1  decoder "program done" strobe.
- GotoEn  in  1  absolute jump to TargetAddr.
- Jump2En  in  1  loop/beq jump to TargetAddr, taken only when Zero=1.
- BranchEn  in  1  relative branch by BranchOff, taken only when Zero=1.
- LoadInst  in  1  current instruction is a data-memory load.
- Zero  in  1  ALU zero flag for the current instruction.
- TargetAddr  in  PC_W  absolute target from the jump LUT.
- BranchOff  in  OFF_W  signed two's-complement relative offset.
- ProgCtr  out  PC_W  address to the instruction ROM.
- WrSuppress  out  1  datapath must block RegWrEn/MemWrEn/BitWriteEn this cycle.
- Busy  out  1  high in RUN and WAIT.
- Done  out  1  level, high in DONE.

Behaviour:
- States: IDLE, RUN, WAIT, DONE.
- Reset (any state, including mid-load): state=IDLE, ProgCtr=START_ADDR, stall counter=0, Busy=0, Done=0, WrSuppress=1.
- IDLE:
  - WrSuppress=1.
  - Start=1: next cycle ProgCtr=START_ADDR, state=RUN.
  - All decoder strobes are ignored.
- RUN, next-PC priority (evaluated every cycle):
  1. Ack: PC holds, state becomes DONE, and the current instruction's writes are allowed (WrSuppress=0).
  2. LoadInst with LOAD_STALL>0: WrSuppress=1, PC holds, stall counter=LOAD_STALL-1, state becomes WAIT.
  3. GotoEn: PC=TargetAddr.
  4. Jump2En and Zero: PC=TargetAddr.
  5. BranchEn and Zero: PC = PC + sign-extended BranchOff, modulo 2^PC_W.
  6. Otherwise: PC = PC+1, modulo 2^PC_W; PC=2^PC_W-1 wraps to 0 with no flag.
- Jump2En or BranchEn with Zero=0 falls through to PC+1.
- Simultaneous strobes resolve strictly by the priority above; no error is raised.
- LoadInst with LOAD_STALL=0: behaves as a normal instruction (PC+1).
- WAIT:
  - While the stall counter is nonzero: WrSuppress=1, PC holds, counter decrements.
  - When the counter reaches 0: WrSuppress=0 (load data write completes), PC=PC+1, state=RUN.
  - Decoder strobes are ignored in WAIT.
  - A load therefore occupies LOAD_STALL+1 cycles in total.
- DONE:
  - Done=1, Busy=0, WrSuppress=1, PC holds.
  - Start=1: PC=START_ADDR, state=RUN, Done drops the next cycle.
- Start is ignored in RUN and WAIT.
- Outputs ProgCtr, Busy and Done are registered. WrSuppress is combinational from the state and the RUN inputs.

Optional Feature:
- Macro: FETCH_SEQ_WATCHDOG_EN.
- Enabled:
  - Adds parameter WDOG_LIMIT (default 4096) and output Timeout (1 bit, reset 0).
  - A 16-bit cycle counter clears on entry to RUN from IDLE/DONE and increments each cycle in RUN/WAIT.
  - When the counter reaches WDOG_LIMIT, the block forces state=DONE and sets Timeout=1.
  - Timeout holds until the next Start or Reset.
- Disabled:
  - No counter and no Timeout port.
  - A program without Ack runs indefinitely.

Test Plan:
- Reset, then Start pulse → ProgCtr 0,0,1,2,3 on successive cycles; Busy=1 from cycle 2. Reset asserted mid-run → IDLE, PC=0 the next cycle.
- PC=5, GotoEn=1, Jump2En=1, Zero=1, TargetAddr=40 → PC=40. Same stimulus with Zero=0 and only Jump2En → PC=6.
- PC=20, BranchEn=1, Zero=1, BranchOff=6'b111100 (-4) → PC=16. PC=1023, no strobe → PC=0.
- LOAD_STALL=2, LoadInst at PC=8:
  - PC holds at 8 for 3 cycles.
  - WrSuppress reads 1,1,0.
  - PC=9 on the 4th cycle.
- Ack at PC=12 → Done=1, PC=12 held. Start → PC=0 and Done=0 the next cycle. Start pulsed while in RUN has no effect.
- Watchdog (macro on, WDOG_LIMIT=10): loop with GotoEn to the same address → Timeout=1 and Done=1 after 10 RUN cycles.
